fft_out_reorder: RTL and testbench

Streaming reorder stage directly downstream of fft_multimode. It consumes FFT output frames delivered in bit-reversed index order and re-emits them in natural order 0..N-1 for downstream consumers and result-dump benches. It uses a ping-pong buffer of two banks so the FFT output can stream back-to-back frames without stalling. Frame length N = 64/128/256/512 is selected by np, with the same encoding as fft_multimode.

---
 rtl/fft_out_reorder.sv | 185 ++++++++++++++++++
 tb/tb_fft_out_reorder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: takes FFT output frames in bit-reversed order
// and streams them back out in natural order, one sample per cycle.
module fft_out_reorder #(
    parameter int DW        = 16,
    parameter int LOG2_NMAX = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    np,
    input  logic          valid_in,
    input  logic          sop_in,
    input  logic [DW-1:0] x_re,
    input  logic [DW-1:0] x_im,
    output logic          valid_out,
    output logic          sop_out,
    output logic          eop_out,
    output logic [DW-1:0] y_re,
    output logic [DW-1:0] y_im,
    output logic          frame_err
);

    // state  | meaning
    // W_IDLE | waiting for sop_in; non-sop samples are dropped
    // W_FILL | writing a frame into bank r_wbank at bit-reversed addresses
    // R_IDLE | nothing to read; starts reading as soon as bank r_rbank is full
    // R_RUN  | issuing one natural-order read per cycle from bank r_rbank

    localparam int AW    = LOG2_NMAX;
    localparam int DEPTH = 1 << AW;

    typedef enum logic {W_IDLE, W_FILL} wstate_t;
    typedef enum logic {R_IDLE, R_RUN}  rstate_t;

    function automatic logic [AW-1:0] last_idx(input logic [1:0] n);
        last_idx = AW'((64 << n) - 1);
    endfunction

    logic [2*DW-1:0] r_mem [0:2*DEPTH-1];

    wstate_t          r_wstate, w_wstate_nxt;
    rstate_t          r_rstate, w_rstate_nxt;
    logic [AW-1:0]    r_wcnt, w_wcnt_nxt;
    logic [AW-1:0]    r_rcnt;
    logic [1:0]       r_frame_np;
    logic             r_wbank, r_rbank;
    logic [1:0]       r_full;
    logic [1:0][1:0]  r_tag_np;

    logic             w_blocked, w_sop_acc, w_we, w_done, w_err;
    logic             w_re, w_rlast;
    logic [AW-1:0]    w_wrev, w_waddr, w_wlast_idx, w_rlast_idx;

    assign w_blocked   = r_full[r_wbank];
    assign w_sop_acc   = valid_in & sop_in & ~w_blocked;
    assign w_wlast_idx = last_idx(r_frame_np);
    assign w_rlast_idx = last_idx(r_tag_np[r_rbank]);

    always_comb begin
        w_wrev = '0;
        for (int i = 0; i < AW; i++) begin
            w_wrev[i] = r_wcnt[AW-1-i];
        end
    end

    // Full-width reversal shifted down so only the low L bits are reversed.
    always_comb begin
        w_waddr = '0;
        if (!sop_in) begin
            case (r_frame_np)
                2'd0:    w_waddr = w_wrev >> (AW - 6);
                2'd1:    w_waddr = w_wrev >> (AW - 7);
                2'd2:    w_waddr = w_wrev >> (AW - 8);
                default: w_waddr = w_wrev >> (AW - 9);
            endcase
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_wcnt_nxt   = r_wcnt;
        w_we         = 1'b0;
        w_done       = 1'b0;
        w_err        = 1'b0;
        if (valid_in) begin
            if (w_blocked) begin
                w_err        = 1'b1;
                w_wstate_nxt = W_IDLE;
                w_wcnt_nxt   = '0;
            end else if (sop_in) begin
                w_we         = 1'b1;
                w_err        = (r_wstate == W_FILL);
                w_wcnt_nxt   = AW'(1);
                w_wstate_nxt = W_FILL;
            end else if (r_wstate == W_FILL) begin
                w_we = 1'b1;
                if (r_wcnt == w_wlast_idx) begin
                    w_done       = 1'b1;
                    w_wcnt_nxt   = '0;
                    w_wstate_nxt = W_IDLE;
                end else begin
                    w_wcnt_nxt = r_wcnt + 1'b1;
                end
            end
        end
    end

    // The first read is issued from R_IDLE in the same cycle the bank is seen full.
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_re         = 1'b0;
        w_rlast      = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (r_full[r_rbank]) begin
                    w_re         = 1'b1;
                    w_rstate_nxt = R_RUN;
                end
            end
            default: w_re = 1'b1;
        endcase
        if (w_re && (r_rcnt == w_rlast_idx)) begin
            w_rlast      = 1'b1;
            w_rstate_nxt = r_full[~r_rbank] ? R_RUN : R_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate   <= W_IDLE;
            r_wcnt     <= '0;
            r_frame_np <= '0;
            r_wbank    <= 1'b0;
            r_rstate   <= R_IDLE;
            r_rcnt     <= '0;
            r_rbank    <= 1'b0;
            r_full     <= '0;
            r_tag_np   <= '0;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_wcnt   <= w_wcnt_nxt;
            r_rstate <= w_rstate_nxt;
            if (w_sop_acc) begin
                r_frame_np <= np;
            end
            if (w_done) begin
                r_full[r_wbank]   <= 1'b1;
                r_tag_np[r_wbank] <= r_frame_np;
                r_wbank           <= ~r_wbank;
            end
            if (w_re) begin
                r_rcnt <= w_rlast ? '0 : r_rcnt + 1'b1;
            end
            if (w_rlast) begin
                r_full[r_rbank] <= 1'b0;
                r_rbank         <= ~r_rbank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[{r_wbank, w_waddr}] <= {x_re, x_im};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            sop_out   <= 1'b0;
            eop_out   <= 1'b0;
            frame_err <= 1'b0;
            y_re      <= '0;
            y_im      <= '0;
        end else begin
            valid_out <= w_re;
            sop_out   <= w_re && (r_rcnt == '0);
            eop_out   <= w_rlast;
            frame_err <= w_err;
            if (w_re) begin
                {y_re, y_im} <= r_mem[{r_rbank, r_rcnt}];
            end
        end
    end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder: frames are sent in bit-reversed order
// with data seed+bitrev(j), so natural output k must carry seed+k.
module tb_fft_out_reorder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  np = 2'b00;
    logic        valid_in = 1'b0;
    logic        sop_in = 1'b0;
    logic [15:0] x_re = '0;
    logic [15:0] x_im = '0;
    logic        valid_out, sop_out, eop_out, frame_err;
    logic [15:0] y_re, y_im;

    fft_out_reorder #(.DW(16), .LOG2_NMAX(9)) dut (
        .clk(clk), .rst_n(rst_n), .np(np), .valid_in(valid_in), .sop_in(sop_in),
        .x_re(x_re), .x_im(x_im), .valid_out(valid_out), .sop_out(sop_out),
        .eop_out(eop_out), .y_re(y_re), .y_im(y_im), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] q_re[$];
    logic [15:0] q_im[$];
    bit          q_sop[$];
    bit          q_eop[$];
    int          q_cyc[$];
    int          ferr_cnt = 0;

    always @(negedge clk) begin
        if (valid_out) begin
            q_re.push_back(y_re);
            q_im.push_back(y_im);
            q_sop.push_back(sop_out);
            q_eop.push_back(eop_out);
            q_cyc.push_back(cyc);
        end
        if (frame_err) ferr_cnt++;
    end

    int errors = 0;
    int checks = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] brev(input int j, input int L);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < L; i++) r[i] = j[L-1-i];
        return r;
    endfunction

    // Number of wrong data/flag/contiguity entries in one captured frame.
    function automatic int frame_bad(input int base, input int n, input logic [15:0] seed);
        int bad;
        logic [15:0] e;
        bad = 0;
        if (q_re.size() < base + n) return n;
        for (int k = 0; k < n; k++) begin
            e = seed + 16'(k);
            if (q_re[base+k] !== e) bad++;
            if (q_im[base+k] !== ~e) bad++;
            if (q_sop[base+k] !== (k == 0)) bad++;
            if (q_eop[base+k] !== (k == n - 1)) bad++;
            if (k > 0 && q_cyc[base+k] != q_cyc[base+k-1] + 1) bad++;
        end
        return bad;
    endfunction

    task automatic drive(input logic v, input logic s, input logic [1:0] n,
                         input logic [15:0] re, input logic [15:0] im);
        @(posedge clk);
        #1;
        valid_in = v;
        sop_in   = s;
        np       = n;
        x_re     = re;
        x_im     = im;
    endtask

    task automatic idle(input int c);
        for (int i = 0; i < c; i++) drive(1'b0, 1'b0, np, 16'h0, 16'h0);
    endtask

    task automatic send_frame(input int L, input logic [1:0] np0, input logic [15:0] seed,
                              input int gap_every, input int flip_at, input logic [1:0] np_flip,
                              output int t_last);
        logic [1:0]  npv;
        logic [15:0] d;
        npv = np0;
        for (int j = 0; j < (1 << L); j++) begin
            if (gap_every > 0 && j > 0 && (j % gap_every) == 0) drive(1'b0, 1'b0, npv, 16'h0, 16'h0);
            if (j == flip_at) npv = np_flip;
            d = seed + brev(j, L);
            drive(1'b1, j == 0, npv, d, ~d);
        end
        t_last = cyc;
    endtask

    task automatic wait_out(input int base, input int n, input int budget);
        for (int i = 0; i < budget && (q_re.size() - base) < n; i++) @(negedge clk);
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
        checks++; if (sop_out !== 1'b0) begin errors++; $display("FAIL reset_sop: got %b expected 0", sop_out); end
        checks++; if (eop_out !== 1'b0) begin errors++; $display("FAIL reset_eop: got %b expected 0", eop_out); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
        checks++; if (y_re !== 16'h0) begin errors++; $display("FAIL reset_yre: got %h expected 0000", y_re); end
        checks++; if (y_im !== 16'h0) begin errors++; $display("FAIL reset_yim: got %h expected 0000", y_im); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_np64_single;
        int base, f0, t, bad, first;
        base = q_re.size();
        f0 = ferr_cnt;
        send_frame(6, 2'b00, 16'h0000, 0, -1, 2'b00, t);
        idle(1);
        wait_out(base, 64, 400);
        first = (q_re.size() > base) ? q_cyc[base] : -1;
        bad = frame_bad(base, 64, 16'h0000);
        checks++; if (q_re.size() - base !== 64) begin errors++; $display("FAIL np64_count: got %0d expected 64", q_re.size() - base); end
        checks++; if (first !== t + 2) begin errors++; $display("FAIL np64_latency: first valid cycle %0d expected %0d", first, t + 2); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL np64_data: %0d bad entries expected 0", bad); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL np64_ferr: %0d pulses expected 0", ferr_cnt - f0); end
    endtask

    task automatic test_back_to_back;
        int base, f0, t1, t2, bad_a, bad_b, first, seam;
        base = q_re.size();
        f0 = ferr_cnt;
        send_frame(9, 2'b11, 16'h1000, 0, -1, 2'b11, t1);
        send_frame(9, 2'b11, 16'h3000, 0, -1, 2'b11, t2);
        idle(1);
        wait_out(base, 1024, 3000);
        first = (q_re.size() > base) ? q_cyc[base] : -1;
        seam = (q_re.size() >= base + 513) ? (q_cyc[base+512] - q_cyc[base+511]) : -1;
        bad_a = frame_bad(base, 512, 16'h1000);
        bad_b = frame_bad(base + 512, 512, 16'h3000);
        checks++; if (q_re.size() - base !== 1024) begin errors++; $display("FAIL b2b_count: got %0d expected 1024", q_re.size() - base); end
        checks++; if (first !== t1 + 2) begin errors++; $display("FAIL b2b_latency: first valid cycle %0d expected %0d", first, t1 + 2); end
        checks++; if (bad_a !== 0) begin errors++; $display("FAIL b2b_frame_a: %0d bad entries expected 0", bad_a); end
        checks++; if (bad_b !== 0) begin errors++; $display("FAIL b2b_frame_b: %0d bad entries expected 0", bad_b); end
        checks++; if (seam !== 1) begin errors++; $display("FAIL b2b_seam: cycle step %0d expected 1", seam); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL b2b_ferr: %0d pulses expected 0", ferr_cnt - f0); end
    endtask

    task automatic test_gaps;
        int base, f0, t, bad, first;
        base = q_re.size();
        f0 = ferr_cnt;
        send_frame(7, 2'b01, 16'h2200, 2, -1, 2'b01, t);
        idle(1);
        wait_out(base, 128, 600);
        first = (q_re.size() > base) ? q_cyc[base] : -1;
        bad = frame_bad(base, 128, 16'h2200);
        checks++; if (q_re.size() - base !== 128) begin errors++; $display("FAIL gaps_count: got %0d expected 128", q_re.size() - base); end
        checks++; if (first !== t + 2) begin errors++; $display("FAIL gaps_latency: first valid cycle %0d expected %0d", first, t + 2); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL gaps_data: %0d bad entries expected 0", bad); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL gaps_ferr: %0d pulses expected 0", ferr_cnt - f0); end
    endtask

    task automatic test_restart;
        int base, f0, t, bad;
        logic [15:0] d;
        base = q_re.size();
        f0 = ferr_cnt;
        for (int j = 0; j < 100; j++) begin
            d = 16'h5000 + brev(j, 8);
            drive(1'b1, j == 0, 2'b10, d, ~d);
        end
        send_frame(8, 2'b10, 16'h7000, 0, -1, 2'b10, t);
        idle(1);
        wait_out(base, 256, 1000);
        bad = frame_bad(base, 256, 16'h7000);
        checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL restart_ferr: %0d pulses expected 1", ferr_cnt - f0); end
        checks++; if (q_re.size() - base !== 256) begin errors++; $display("FAIL restart_count: got %0d expected 256", q_re.size() - base); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL restart_data: %0d bad entries expected 0", bad); end
    endtask

    task automatic test_np_change;
        int base, f0, t1, t2, bad1, bad2;
        base = q_re.size();
        f0 = ferr_cnt;
        send_frame(6, 2'b00, 16'h2000, 0, 20, 2'b11, t1);
        send_frame(9, 2'b11, 16'h4000, 0, 100, 2'b01, t2);
        idle(1);
        wait_out(base, 576, 2000);
        bad1 = frame_bad(base, 64, 16'h2000);
        bad2 = frame_bad(base + 64, 512, 16'h4000);
        checks++; if (q_re.size() - base !== 576) begin errors++; $display("FAIL npchg_count: got %0d expected 576", q_re.size() - base); end
        checks++; if (bad1 !== 0) begin errors++; $display("FAIL npchg_frame1: %0d bad entries expected 0", bad1); end
        checks++; if (bad2 !== 0) begin errors++; $display("FAIL npchg_frame2: %0d bad entries expected 0", bad2); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL npchg_ferr: %0d pulses expected 0", ferr_cnt - f0); end
    endtask

    task automatic test_reset_mid_read;
        int base, base2, t, bad;
        base = q_re.size();
        send_frame(6, 2'b00, 16'h6000, 0, -1, 2'b00, t);
        idle(1);
        for (int i = 0; i < 300 && (q_re.size() - base) < 31; i++) @(negedge clk);
        checks++; if (q_re.size() - base !== 31) begin errors++; $display("FAIL midrst_reach: got %0d outputs expected 31", q_re.size() - base); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({valid_out, sop_out, eop_out} !== 3'b000) begin errors++; $display("FAIL midrst_flags: got %b expected 000", {valid_out, sop_out, eop_out}); end
        checks++; if ({y_re, y_im} !== 32'h0) begin errors++; $display("FAIL midrst_data: got %h expected 00000000", {y_re, y_im}); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        base2 = q_re.size();
        repeat (80) @(negedge clk);
        checks++; if (q_re.size() - base2 !== 0) begin errors++; $display("FAIL midrst_stale: got %0d outputs expected 0", q_re.size() - base2); end
        send_frame(6, 2'b00, 16'h0800, 0, -1, 2'b00, t);
        idle(1);
        wait_out(base2, 64, 400);
        bad = frame_bad(base2, 64, 16'h0800);
        checks++; if (q_re.size() - base2 !== 64) begin errors++; $display("FAIL midrst_count: got %0d expected 64", q_re.size() - base2); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL midrst_data_after: %0d bad entries expected 0", bad); end
    endtask

    initial begin
        test_reset();
        test_np64_single();
        test_back_to_back();
        test_gaps();
        test_restart();
        test_np_change();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
